// File: rtl/huff_bigval_ctrl.sv
// Big-values region controller: walks the pair index, selects the Huffman table
// per region, meters serial bits into the decoder bank and writes decoded pairs.
module huff_bigval_ctrl #(
    parameter int MAX_PAIRS     = 288,
    parameter int MAX_WORD_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  big_values,
    input  logic [4:0]  table_select0,
    input  logic [4:0]  table_select1,
    input  logic [4:0]  table_select2,
    input  logic [9:0]  region1_start,
    input  logic [9:0]  region2_start,
    input  logic        bit_valid,
    input  logic        bit_data,
    output logic        bit_ready,
    output logic [4:0]  dec_table,
    output logic        dec_axiiv,
    output logic        dec_axiid,
    input  logic        dec_axiov,
    input  logic [15:0] dec_x,
    input  logic [15:0] dec_y,
    output logic        dec_flush,
    output logic        pair_valid,
    output logic [9:0]  pair_addr,
    output logic [15:0] pair_x,
    output logic [15:0] pair_y,
    output logic [15:0] bits_used,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);
    localparam int WBW = $clog2(MAX_WORD_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_DECODE, S_ZFILL, S_FINISH, S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      pair_cnt_q, pair_cnt_d;
    logic [15:0]     bits_used_q, bits_used_d;
    logic [4:0]      dec_table_q, dec_table_d;
    logic [WBW-1:0]  wbits_q, wbits_d;
    logic [9:0]      zend_q, zend_d;
    logic [9:0]      bv_q, r1_q, r2_q;
    logic [4:0]      ts0_q, ts1_q, ts2_q;
    logic            cfg_load;
    logic [4:0]      act_tab;
    logic [9:0]      act_end;
    logic            cfg_bad;
    logic            bit_ready_c, dec_axiiv_c, dec_flush_c, pair_valid_c, done_c, err_c;
    logic [15:0]     pair_x_c, pair_y_c;

    // Region lookup; a boundary at 0 or beyond big_values yields an empty region.
    always_comb begin
        act_tab = ts2_q;
        act_end = bv_q;
        if (pair_cnt_q < r1_q) begin
            act_tab = ts0_q;
            act_end = r1_q;
        end else if (pair_cnt_q < r2_q) begin
            act_tab = ts1_q;
            act_end = r2_q;
        end
        if (act_end > bv_q) act_end = bv_q;
    end

    assign cfg_bad = (int'(bv_q) > MAX_PAIRS) || (r2_q < r1_q);

    always_comb begin
        state_d      = state_q;
        pair_cnt_d   = pair_cnt_q;
        bits_used_d  = bits_used_q;
        dec_table_d  = dec_table_q;
        wbits_d      = wbits_q;
        zend_d       = zend_q;
        cfg_load     = 1'b0;
        bit_ready_c  = 1'b0;
        dec_axiiv_c  = 1'b0;
        dec_flush_c  = 1'b0;
        pair_valid_c = 1'b0;
        pair_x_c     = 16'd0;
        pair_y_c     = 16'd0;
        done_c       = 1'b0;
        err_c        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SETUP;
                    cfg_load    = 1'b1;
                    pair_cnt_d  = 10'd0;
                    bits_used_d = 16'd0;
                    dec_flush_c = 1'b1;
                end
            end
            S_SETUP: begin
                wbits_d     = '0;
                dec_table_d = act_tab;
                zend_d      = act_end;
                if (pair_cnt_q == bv_q)                                   state_d = S_FINISH;
                else if (cfg_bad || act_tab == 5'd4 || act_tab == 5'd14) state_d = S_ERROR;
                else if (act_tab == 5'd0)                                 state_d = S_ZFILL;
                else                                                      state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_axiov) begin
                    pair_valid_c = 1'b1;
                    pair_x_c     = dec_x;
                    pair_y_c     = dec_y;
                    pair_cnt_d   = pair_cnt_q + 10'd1;
                    // The last pair needs no region re-evaluation, so finish directly.
                    state_d = (pair_cnt_q + 10'd1 == bv_q) ? S_FINISH : S_SETUP;
                end else if (wbits_q == WBW'(MAX_WORD_BITS)) begin
                    state_d = S_ERROR;
                end else begin
                    bit_ready_c = bit_valid;
                    dec_axiiv_c = bit_valid;
                    if (bit_valid) begin
                        bits_used_d = bits_used_q + 16'd1;
                        wbits_d     = wbits_q + WBW'(1);
                    end
                end
            end
            S_ZFILL: begin
                pair_valid_c = 1'b1;
                pair_cnt_d   = pair_cnt_q + 10'd1;
                if (pair_cnt_q + 10'd1 >= zend_q) state_d = S_SETUP;
            end
            S_FINISH: begin
                done_c      = 1'b1;
                dec_flush_c = 1'b1;
                state_d     = S_IDLE;
            end
            S_ERROR: begin
                err_c       = 1'b1;
                dec_flush_c = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pair_cnt_q  <= 10'd0;
            bits_used_q <= 16'd0;
            dec_table_q <= 5'd0;
            wbits_q     <= '0;
            zend_q      <= 10'd0;
            bv_q        <= 10'd0;
            r1_q        <= 10'd0;
            r2_q        <= 10'd0;
            ts0_q       <= 5'd0;
            ts1_q       <= 5'd0;
            ts2_q       <= 5'd0;
        end else begin
            state_q     <= state_d;
            pair_cnt_q  <= pair_cnt_d;
            bits_used_q <= bits_used_d;
            dec_table_q <= dec_table_d;
            wbits_q     <= wbits_d;
            zend_q      <= zend_d;
            if (cfg_load) begin
                bv_q  <= big_values;
                r1_q  <= region1_start;
                r2_q  <= region2_start;
                ts0_q <= table_select0;
                ts1_q <= table_select1;
                ts2_q <= table_select2;
            end
        end
    end

    // Outputs are forced to their idle values while reset is held.
    assign bit_ready  = rst & bit_ready_c;
    assign dec_axiiv  = rst & dec_axiiv_c;
    assign dec_axiid  = bit_data;
    assign dec_flush  = ~rst | dec_flush_c;
    assign dec_table  = dec_table_q;
    assign pair_valid = rst & pair_valid_c;
    assign pair_addr  = pair_cnt_q;
    assign pair_x     = pair_x_c;
    assign pair_y     = pair_y_c;
    assign bits_used  = bits_used_q;
    assign busy       = rst & (state_q != S_IDLE);
    assign done       = rst & done_c;
    assign err        = rst & err_c;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_huff_bigval_ctrl.sv
// Bench for huff_bigval_ctrl with a small behavioural HT_15 decoder and a pair scoreboard.
module tb_huff_bigval_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  big_values = '0;
    logic [4:0]  table_select0 = '0, table_select1 = '0, table_select2 = '0;
    logic [9:0]  region1_start = '0, region2_start = '0;
    logic        bit_valid = 1'b0, bit_data = 1'b0;
    logic        bit_ready;
    logic [4:0]  dec_table;
    logic        dec_axiiv, dec_axiid;
    logic        dec_axiov = 1'b0;
    logic [15:0] dec_x = '0, dec_y = '0;
    logic        dec_flush, pair_valid;
    logic [9:0]  pair_addr;
    logic [15:0] pair_x, pair_y, bits_used;
    logic        busy, done, err;
    logic [2:0]  dbg_state;

    huff_bigval_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .big_values(big_values),
        .table_select0(table_select0), .table_select1(table_select1), .table_select2(table_select2),
        .region1_start(region1_start), .region2_start(region2_start),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
        .dec_table(dec_table), .dec_axiiv(dec_axiiv), .dec_axiid(dec_axiid),
        .dec_axiov(dec_axiov), .dec_x(dec_x), .dec_y(dec_y), .dec_flush(dec_flush),
        .pair_valid(pair_valid), .pair_addr(pair_addr), .pair_x(pair_x), .pair_y(pair_y),
        .bits_used(bits_used), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_pair_cyc = 0;
    logic in_wait = 1'b0;
    logic gap_en  = 1'b0;
    logic phase   = 1'b0;
    logic bit_q[$];
    logic [46:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [46:0] mk(input int t, input int a, input int x, input int y);
        return {5'(t), 10'(a), 16'(x), 16'(y)};
    endfunction

    task automatic push_bits(input string s);
        for (int i = 0; i < s.len(); i++) bit_q.push_back(s[i] == "1");
    endtask

    // Environment: bit source, HT_15 decoder model and output monitors.
    int   m_buf = 0, m_len = 0, mx = 0, my = 0;
    logic m_sxp = 1'b0, m_syp = 1'b0;
    always begin
        logic s_hs, s_iiv, s_iid, s_flush, emit, matched;
        @(negedge clk);
        s_hs    = bit_valid && bit_ready;
        s_iiv   = dec_axiiv;
        s_iid   = dec_axiid;
        s_flush = dec_flush;
        if (dec_axiov) begin
            check("ready_in_ov", bit_ready, 1'b0);
            check("iiv_in_ov", dec_axiiv, 1'b0);
        end
        if (pair_valid) begin
            if (exp_q.size() == 0) check("pair_extra", pair_valid, 1'b0);
            else check("pair", {dec_table, pair_addr, pair_x, pair_y}, exp_q.pop_front());
            last_pair_cyc = cyc;
        end
        if ((done || err) && !in_wait) check("stray_end", {done, err}, 2'b00);
        @(posedge clk);
        cyc++;
        #1;
        if (s_hs && bit_q.size() > 0) void'(bit_q.pop_front());
        emit = 1'b0;
        dec_axiov = 1'b0;
        if (s_flush) begin
            m_buf = 0; m_len = 0; m_sxp = 1'b0; m_syp = 1'b0;
        end else if (s_iiv) begin
            if (m_sxp) begin
                if (s_iid) mx = -mx;
                m_sxp = 1'b0;
                emit  = !m_syp;
            end else if (m_syp) begin
                if (s_iid) my = -my;
                m_syp = 1'b0;
                emit  = 1'b1;
            end else begin
                m_buf = m_buf * 2 + int'(s_iid);
                m_len++;
                matched = 1'b1;
                if      (m_len == 3 && m_buf == 7)  begin mx = 0; my = 0; end
                else if (m_len == 3 && m_buf == 5)  begin mx = 1; my = 1; end
                else if (m_len == 4 && m_buf == 12) begin mx = 0; my = 1; end
                else if (m_len == 4 && m_buf == 13) begin mx = 1; my = 0; end
                else matched = 1'b0;
                if (matched) begin
                    m_buf = 0; m_len = 0;
                    m_sxp = (mx != 0);
                    m_syp = (my != 0);
                    emit  = !m_sxp && !m_syp;
                end
            end
        end
        if (emit) begin
            dec_axiov = 1'b1;
            dec_x = 16'(mx);
            dec_y = 16'(my);
        end
        phase = ~phase;
        bit_valid = (bit_q.size() > 0) && (!gap_en || phase);
        bit_data  = (bit_q.size() > 0) ? bit_q[0] : 1'b0;
    end

    task automatic start_granule(input int bv, input int t0, input int t1, input int t2,
                                 input int r1, input int r2);
        big_values = 10'(bv);
        table_select0 = 5'(t0); table_select1 = 5'(t1); table_select2 = 5'(t2);
        region1_start = 10'(r1); region2_start = 10'(r2);
        start = 1'b1;
        #1 check("flush_on_start", dec_flush, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_run", busy, 1'b1);
    endtask

    task automatic wait_end(input int max, output logic got_done, output logic got_err,
                            output int end_cyc);
        got_done = 1'b0; got_err = 1'b0; end_cyc = 0;
        in_wait = 1'b1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done || err) begin
                got_done = done; got_err = err; end_cyc = cyc;
                break;
            end
        end
        if (!got_done && !got_err) begin
            n_checks++; n_err++;
            $display("FAIL timeout: no done/err within %0d cycles", max);
        end
        @(posedge clk); #1;
        in_wait = 1'b0;
    endtask

    task automatic run_ok(input string tag, input int nbits);
        logic gd, ge;
        int   ec;
        wait_end(300, gd, ge, ec);
        check({tag, "_done"}, gd, 1'b1);
        check({tag, "_err"}, ge, 1'b0);
        check({tag, "_bits"}, bits_used, 16'(nbits));
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic gd, ge;
        int   ec;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_pv", pair_valid, 1'b0);
        check("rst_ready", bit_ready, 1'b0);
        check("rst_iiv", dec_axiiv, 1'b0);
        check("rst_flush", dec_flush, 1'b1);
        check("rst_bits", bits_used, 16'd0);
        check("rst_table", dec_table, 5'd0);
        check("rst_addr", pair_addr, 10'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Table 15 only via zero-length regions 0/1 (their bad tables must be skipped)
        push_bits("11110101");
        exp_q.push_back(mk(15, 0, 0, 0));
        exp_q.push_back(mk(15, 1, 1, -1));
        start_granule(2, 4, 4, 15, 0, 0);
        wait_end(300, gd, ge, ec);
        check("a_done", gd, 1'b1);
        check("a_err", ge, 1'b0);
        check("a_done_lat", ec - last_pair_cyc, 1);
        check("a_bits", bits_used, 16'd8);
        check("a_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1 check("a_bits_hold", bits_used, 16'd8);

        // Same stream with bit_valid gapped, regions 1/2 beyond big_values
        gap_en = 1'b1;
        push_bits("11110101");
        exp_q.push_back(mk(15, 0, 0, 0));
        exp_q.push_back(mk(15, 1, 1, -1));
        start_granule(2, 15, 4, 4, 7, 7);
        run_ok("b", 8);
        gap_en = 1'b0;

        // Zero region then table 15
        push_bits("111");
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, i, 0, 0));
        exp_q.push_back(mk(15, 3, 0, 0));
        start_granule(4, 0, 15, 15, 3, 4);
        run_ok("c", 3);

        // Back-to-back codewords; a start while busy must be ignored
        push_bits("111110001101110111111");
        exp_q.push_back(mk(15, 0, 0, 0));
        exp_q.push_back(mk(15, 1, 0, 1));
        exp_q.push_back(mk(15, 2, -1, 0));
        exp_q.push_back(mk(15, 3, -1, -1));
        exp_q.push_back(mk(15, 4, 0, 0));
        start_granule(5, 15, 15, 15, 2, 4);
        @(posedge clk); #1;
        big_values = 10'd1; table_select0 = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_ok("d", 21);

        // Forbidden table: err two cycles after start, no pairs
        start_granule(1, 4, 4, 4, 1, 1);
        in_wait = 1'b1;
        check("e_err_early", err, 1'b0);
        @(posedge clk); #1;
        check("e_err_pulse", err, 1'b1);
        check("e_bits", bits_used, 16'd0);
        @(posedge clk); #1;
        check("e_err_once", err, 1'b0);
        check("e_idle", busy, 1'b0);
        in_wait = 1'b0;

        // Region2 before region1 is a configuration error
        start_granule(3, 15, 15, 15, 2, 1);
        wait_end(10, gd, ge, ec);
        check("f_err", ge, 1'b1);
        check("f_done", gd, 1'b0);

        // All-zero stream: codeword never completes
        for (int i = 0; i < 40; i++) bit_q.push_back(1'b0);
        start_granule(1, 15, 15, 15, 1, 1);
        wait_end(300, gd, ge, ec);
        check("g_err", ge, 1'b1);
        check("g_bits", bits_used, 16'd32);
        bit_q.delete();

        // Reset mid-decode, then a clean decode restarting at address 0
        push_bits("111");
        exp_q.push_back(mk(15, 0, 0, 0));
        start_granule(2, 15, 15, 15, 2, 2);
        repeat (12) @(posedge clk);
        #1 check("h_stalled", busy, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("h_rst_busy", busy, 1'b0);
        check("h_rst_addr", pair_addr, 10'd0);
        check("h_rst_bits", bits_used, 16'd0);
        check("h_rst_flush", dec_flush, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        push_bits("11110101");
        exp_q.push_back(mk(15, 0, 0, 0));
        exp_q.push_back(mk(15, 1, 1, -1));
        start_granule(2, 15, 15, 15, 2, 2);
        run_ok("h", 8);

        // Randomised back-to-back (0,0)/(0,+-1) codewords
        begin
            int n;
            n = $urandom_range(3, 8);
            for (int i = 0; i < n; i++) begin
                int s;
                s = $urandom_range(0, 2);
                if (s == 0) begin push_bits("111");   exp_q.push_back(mk(15, i, 0, 0));  end
                if (s == 1) begin push_bits("11000"); exp_q.push_back(mk(15, i, 0, 1));  end
                if (s == 2) begin push_bits("11001"); exp_q.push_back(mk(15, i, 0, -1)); end
            end
            gap_en = ($urandom_range(0, 1) == 1);
            start_granule(n, 15, 15, 15, n, n);
            wait_end(400, gd, ge, ec);
            check("r_done", gd, 1'b1);
            check("r_left", exp_q.size(), 0);
            check("r_src_empty", bit_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
